// File: rtl/next186_sdr_pkg.sv
// Shared types for the SDRAM command-port scheduler.
package next186_sdr_pkg;

  localparam int unsigned SRC_W = 2;

  // Requester codes as presented on cmd_src.
  typedef enum logic [SRC_W-1:0] {
    SRC_REF = 2'd0,
    SRC_VGA = 2'd1,
    SRC_CPU = 2'd2,
    SRC_DMA = 2'd3
  } src_t;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Command attributes registered alongside the address.
  typedef struct packed {
    logic refresh;
    logic we;
    src_t src;
  } cmd_ctl_t;

  // Round-robin partner of a CPU/DMA grant.
  function automatic src_t rr_other(input src_t s);
    return (s == SRC_CPU) ? SRC_DMA : SRC_CPU;
  endfunction

endpackage

// File: rtl/sdr_refresh_timer.sv
// Refresh cadence: down-counter plus saturating count of owed refreshes.
module sdr_refresh_timer
  import next186_sdr_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REF_PEND_MAX   = 7
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic consume_i,
  output logic pend_ge1_o,
  output logic pend_ge2_o
);

  localparam int unsigned CNT_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam int unsigned PEND_W = $clog2(REF_PEND_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REFRESH_PERIOD - 1);
  localparam logic [PEND_W-1:0] PEND_SAT   = PEND_W'(REF_PEND_MAX);

  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic [PEND_W-1:0] ref_pend_q, ref_pend_d;
  logic              pend_ge1_q, pend_ge2_q;
  logic              tick;

  // Next count and pending value; a tick and a consume together cancel out.
  always_comb begin
    tick       = (ref_cnt_q == '0);
    ref_cnt_d  = tick ? CNT_RELOAD : ref_cnt_q - CNT_W'(1);
    ref_pend_d = ref_pend_q;
    if (tick && !consume_i) begin
      if (ref_pend_q != PEND_SAT) ref_pend_d = ref_pend_q + PEND_W'(1);
    end else if (consume_i && !tick) begin
      if (ref_pend_q != '0) ref_pend_d = ref_pend_q - PEND_W'(1);
    end
  end

  // Counter, pending count and registered threshold flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_cnt_q  <= CNT_RELOAD;
      ref_pend_q <= '0;
      pend_ge1_q <= 1'b0;
      pend_ge2_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      pend_ge1_q <= (ref_pend_d != '0);
      pend_ge2_q <= (ref_pend_d >= PEND_W'(2));
    end
  end

  assign pend_ge1_o = pend_ge1_q;
  assign pend_ge2_o = pend_ge2_q;

endmodule

// File: rtl/sdr_port_scheduler.sv
// Arbitrates the single SDRAM command port among refresh, VGA, CPU and DMA.
module sdr_port_scheduler
  import next186_sdr_pkg::*;
#(
  parameter int unsigned AW             = 21,
  parameter int unsigned REFRESH_PERIOD = 780,
  parameter int unsigned REF_PEND_MAX   = 7,
  parameter int unsigned MAX_VGA_RUN    = 4
) (
  input  logic          SDR_CLK,
  input  logic          RST_N,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_ack,
  output logic          vga_stb,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic          cpu_stb,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_ack,
  output logic          dma_stb,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_refresh,
  output logic          cmd_we,
  output logic [AW-1:0] cmd_addr,
  output logic [1:0]    cmd_src,
  input  logic          data_stb,
  input  logic          cmd_done,
  output logic          busy
);

  localparam int unsigned RUN_W = $clog2(MAX_VGA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_VGA_RUN);

  state_t            state_q, state_d;
  cmd_ctl_t          cmd_q, cmd_d;
  logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
  src_t              rr_q, rr_d;
  logic [RUN_W-1:0]  vga_run_q, vga_run_d;

  logic              pend_ge1, pend_ge2;
  logic              vga_blocked;
  logic              win_valid;
  cmd_ctl_t          win_ctl;
  logic [AW-1:0]     win_addr;
  logic              hs;

  sdr_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .REF_PEND_MAX   (REF_PEND_MAX)
  ) u_refresh (
    .clk_i      (SDR_CLK),
    .rst_ni     (RST_N),
    .consume_i  (hs && cmd_q.refresh),
    .pend_ge1_o (pend_ge1),
    .pend_ge2_o (pend_ge2)
  );

  // Priority arbiter on the live request inputs.
  always_comb begin
    win_valid   = 1'b1;
    win_ctl     = '0;
    win_addr    = '0;
    vga_blocked = (vga_run_q == RUN_MAX) && (cpu_req || dma_req);
    if (pend_ge2) begin
      win_ctl.refresh = 1'b1;
    end else if (vga_req && !vga_blocked) begin
      win_ctl.src = SRC_VGA;
      win_addr    = vga_addr;
    end else if (pend_ge1) begin
      win_ctl.refresh = 1'b1;
    end else if (cpu_req && (!dma_req || rr_q == SRC_CPU)) begin
      win_ctl.src = SRC_CPU;
      win_ctl.we  = cpu_we;
      win_addr    = cpu_addr;
    end else if (dma_req) begin
      win_ctl.src = SRC_DMA;
      win_ctl.we  = dma_we;
      win_addr    = dma_addr;
    end else if (vga_req) begin
      // Starved VGA falls through only when nothing else is eligible.
      win_ctl.src = SRC_VGA;
      win_addr    = vga_addr;
    end else begin
      win_valid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge SDR_CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (win_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) state_d = ST_BUSY;
      ST_BUSY:  if (cmd_done)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, accept pulses and per-word strobe routing.
  always_comb begin
    cmd_valid = (state_q == ST_ISSUE);
    busy      = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
    hs        = cmd_valid && cmd_ready;
    vga_ack   = hs && !cmd_q.refresh && (cmd_q.src == SRC_VGA);
    cpu_ack   = hs && !cmd_q.refresh && (cmd_q.src == SRC_CPU);
    dma_ack   = hs && !cmd_q.refresh && (cmd_q.src == SRC_DMA);
    vga_stb   = data_stb && (state_q == ST_BUSY) && (cmd_q.src == SRC_VGA);
    cpu_stb   = data_stb && (state_q == ST_BUSY) && (cmd_q.src == SRC_CPU);
    dma_stb   = data_stb && (state_q == ST_BUSY) && (cmd_q.src == SRC_DMA);
  end

  // Command capture in IDLE; fairness bookkeeping on each handshake.
  always_comb begin
    cmd_d      = cmd_q;
    cmd_addr_d = cmd_addr_q;
    rr_d       = rr_q;
    vga_run_d  = vga_run_q;
    if (state_q == ST_IDLE && win_valid) begin
      cmd_d      = win_ctl;
      cmd_addr_d = win_addr;
    end
    if (hs && !cmd_q.refresh) begin
      unique case (cmd_q.src)
        SRC_VGA: if (vga_run_q != RUN_MAX) vga_run_d = vga_run_q + RUN_W'(1);
        SRC_CPU, SRC_DMA: begin
          rr_d      = rr_other(cmd_q.src);
          vga_run_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Command register and arbitration history.
  always_ff @(posedge SDR_CLK or negedge RST_N) begin
    if (!RST_N) begin
      cmd_q      <= '0;
      cmd_addr_q <= '0;
      rr_q       <= SRC_CPU;
      vga_run_q  <= '0;
    end else begin
      cmd_q      <= cmd_d;
      cmd_addr_q <= cmd_addr_d;
      rr_q       <= rr_d;
      vga_run_q  <= vga_run_d;
    end
  end

  assign cmd_refresh = cmd_q.refresh;
  assign cmd_we      = cmd_q.we;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_src     = cmd_q.src;

  // Requester and controller protocol expectations.
  a_vga_hold: assert property (@(posedge SDR_CLK) disable iff (!RST_N)
    (vga_req && !vga_ack) |=> (vga_req && $stable(vga_addr)));
  a_cpu_hold: assert property (@(posedge SDR_CLK) disable iff (!RST_N)
    (cpu_req && !cpu_ack) |=> (cpu_req && $stable(cpu_addr) && $stable(cpu_we)));
  a_dma_hold: assert property (@(posedge SDR_CLK) disable iff (!RST_N)
    (dma_req && !dma_ack) |=> (dma_req && $stable(dma_addr) && $stable(dma_we)));
  a_done_busy: assert property (@(posedge SDR_CLK) disable iff (!RST_N)
    cmd_done |-> (state_q == ST_BUSY));

endmodule
